gcd_controller: RTL

Control FSM for the 16-bit Euclid GCD unit. It drives the load and select strobes of `gcd_datapath` and consumes that datapath's compare flags. It sequences operand load, repeated subtract-and-replace, and answer capture, and adds a start/busy/done handshake, an iteration counter and a runaway timeout. It sits between the top-level user logic (switches/buttons on the Nexys4) and the datapath.

---
 rtl/gcd_pkg.sv | 23 ++
 rtl/gcd_iter_counter.sv | 30 +++
 rtl/gcd_controller.sv | 111 +++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared types and constants for the Euclid GCD controller and datapath.
package gcd_pkg;

  localparam int unsigned ITER_W_DEF   = 16;
  localparam int unsigned MAX_ITER_DEF = 65535;

  // Mux-select encodings, shared with gcd_datapath
  localparam logic SEL_EXT  = 1'b0;
  localparam logic SEL_DIFF = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE,
    ST_ERR
  } state_t;

  function automatic logic flags_onehot(input logic eq, input logic lt, input logic gt);
    return (eq & ~lt & ~gt) | (~eq & lt & ~gt) | (~eq & ~lt & gt);
  endfunction

endpackage

// File: rtl/gcd_iter_counter.sv
// Subtraction counter with synchronous clear and saturation at MAX_ITER.
module gcd_iter_counter
  import gcd_pkg::*;
#(
  parameter int unsigned ITER_W   = ITER_W_DEF,
  parameter int unsigned MAX_ITER = MAX_ITER_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              inc,
  output logic [ITER_W-1:0] count,
  output logic              limit
);

  localparam logic [ITER_W-1:0] LIMIT = ITER_W'(MAX_ITER);

  assign limit = (count == LIMIT);

  // Gating inc with limit keeps the count from ever wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc && !limit)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/gcd_controller.sv
// Control FSM for the 16-bit Euclid GCD unit: load, subtract-and-replace,
// answer capture, with start/busy/done handshake and runaway timeout.
module gcd_controller
  import gcd_pkg::*;
#(
  parameter int unsigned ITER_W   = ITER_W_DEF,
  parameter int unsigned MAX_ITER = MAX_ITER_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              a_eq_b,
  input  logic              a_lt_b,
  input  logic              a_gt_b,
  output logic              loadA,
  output logic              loadB,
  output logic              selectA,
  output logic              selectb,
  output logic              loadANS,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  state_t state, state_nx;
  logic   cnt_clear;
  logic   cnt_inc;
  logic   limit;

  gcd_iter_counter #(
    .ITER_W   (ITER_W),
    .MAX_ITER (MAX_ITER)
  ) u_iter_counter (
    .clk   (clk),
    .rst_n (rst),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (iter_count),
    .limit (limit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    loadA     = 1'b0;
    loadB     = 1'b0;
    selectA   = SEL_EXT;
    selectb   = SEL_EXT;
    loadANS   = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start)
          state_nx = ST_LOAD;
      end

      ST_LOAD: begin
        loadA     = 1'b1;
        loadB     = 1'b1;
        cnt_clear = 1'b1;
        state_nx  = ST_RUN;
      end

      // Flag sanity first, then convergence, then budget, then subtract
      ST_RUN: begin
        if (!flags_onehot(a_eq_b, a_lt_b, a_gt_b)) begin
          state_nx = ST_ERR;
        end else if (a_eq_b) begin
          loadANS  = 1'b1;
          state_nx = ST_DONE;
        end else if (limit) begin
          state_nx = ST_ERR;
        end else if (a_gt_b) begin
          loadA   = 1'b1;
          selectA = SEL_DIFF;
          cnt_inc = 1'b1;
        end else begin
          loadB   = 1'b1;
          selectb = SEL_DIFF;
          cnt_inc = 1'b1;
        end
      end

      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end

      ST_ERR: begin
        timeout  = 1'b1;
        state_nx = ST_IDLE;
      end

      default: state_nx = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule
